// File: rtl/pbvi_iter_ctrl_pkg.sv
// Shared definitions for the PBVI value-iteration controller.
//   state_t     controller FSM states
//   W_DEF etc.  default widths and sizes
//   alpha_def_t alpha-set layout at the default sizes [point][state][element]
//   abs_diff    |a - b| of two sign-extended operands, computed one bit wider
//               than the operands so that no span can wrap
package pbvi_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_STEP_REQ,
    S_STEP_WAIT,
    S_CMP,
    S_DONE
  } state_t;

  localparam int W_DEF      = 16;
  localparam int ITER_W_DEF = 16;
  localparam int N_PTS_DEF  = 16;
  localparam int N_ST_DEF   = 2;

  typedef logic [N_PTS_DEF-1:0][N_ST_DEF-1:0][W_DEF-1:0] alpha_def_t;

  // Operands arrive sign-extended to 32 bits; callers keep the low W+1 bits,
  // which always hold the full magnitude because |a - b| <= 2^W.
  function automatic logic [32:0] abs_diff(input logic signed [31:0] a,
                                           input logic signed [31:0] b);
    logic signed [32:0] d;
    d = 33'(a) - 33'(b);
    return d[32] ? $unsigned(-d) : $unsigned(d);
  endfunction

endpackage

// File: rtl/pbvi_iter_ctrl_if.sv
// Start/done handshake between the iteration controller and the backup engine.
//   step_start     one-cycle launch pulse (controller -> engine)
//   step_alpha     current alpha set, stable from launch until step_done
//   step_done      one-cycle result-valid pulse (engine -> controller)
//   step_alpha_res new alpha set, valid with step_done
//   step_action    per-point chosen action, valid with step_done
interface pbvi_iter_ctrl_if
  import pbvi_pkg::*;
#(
  parameter int N_PTS = N_PTS_DEF,
  parameter int N_ST  = N_ST_DEF,
  parameter int N_ACT = 3,
  parameter int W     = W_DEF,
  parameter int A_W   = $clog2(N_ACT)
);
  logic                      step_start;
  logic [N_PTS*N_ST*W-1:0]   step_alpha;
  logic                      step_done;
  logic [N_PTS*N_ST*W-1:0]   step_alpha_res;
  logic [N_PTS*A_W-1:0]      step_action;

  modport master (
    output step_start, step_alpha,
    input  step_done, step_alpha_res, step_action
  );

  modport slave (
    input  step_start, step_alpha,
    output step_done, step_alpha_res, step_action
  );
endinterface

// File: rtl/pbvi_iter_ctrl_point_delta.sv
// pbvi_point_delta: combinational max |nxt - cur| over the N_ST elements of a
// single belief point.
//   cur_pt  committed alpha vector of the point
//   nxt_pt  freshly backed-up alpha vector of the point
//   delta   largest element magnitude change, unsigned W+1 bits (no saturation)
module pbvi_point_delta
  import pbvi_pkg::*;
#(
  parameter int N_ST = N_ST_DEF,
  parameter int W    = W_DEF
) (
  input  logic [N_ST-1:0][W-1:0] cur_pt,
  input  logic [N_ST-1:0][W-1:0] nxt_pt,
  output logic [W:0]             delta
);

  logic [W:0] d_s;

  always_comb begin
    delta = '0;
    d_s   = '0;
    for (int s = 0; s < N_ST; s++) begin
      d_s = (W+1)'(abs_diff(32'(signed'(nxt_pt[s])), 32'(signed'(cur_pt[s]))));
      if (d_s > delta) delta = d_s;
    end
  end

endmodule

// File: rtl/pbvi_iter_ctrl.sv
// pbvi_iter_ctrl: PBVI value-iteration loop controller.
// Loads an initial alpha set, launches the backup engine repeatedly and stops
// on the iteration limit or when the largest per-point change is <= epsilon.
//   clk, rst_n        clock, asynchronous active-low reset
//   start, abort      solve request (IDLE only) / cancel (any busy state)
//   max_iter, epsilon, alpha_in   solve arguments, sampled on start
//   eng               master side of the backup-engine handshake
//   busy, done, converged, aborted   status
//   iter_count, last_delta           progress of the current/last solve
//   alpha_out, point_action          committed alpha set / latest actions
module pbvi_iter_ctrl
  import pbvi_pkg::*;
#(
  parameter int N_PTS  = N_PTS_DEF,
  parameter int N_ST   = N_ST_DEF,
  parameter int N_ACT  = 3,
  parameter int W      = W_DEF,
  parameter int ITER_W = ITER_W_DEF,
  parameter int A_W    = $clog2(N_ACT)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [ITER_W-1:0]       max_iter,
  input  logic [W-1:0]            epsilon,
  input  logic [N_PTS*N_ST*W-1:0] alpha_in,
  pbvi_iter_ctrl_if.master        eng,
  output logic                    busy,
  output logic                    done,
  output logic                    converged,
  output logic                    aborted,
  output logic [ITER_W-1:0]       iter_count,
  output logic [W:0]              last_delta,
  output logic [N_PTS*N_ST*W-1:0] alpha_out,
  output logic [N_PTS*A_W-1:0]    point_action
);

  localparam int P_W = $clog2(N_PTS);

  typedef logic [N_PTS-1:0][N_ST-1:0][W-1:0] alpha_t;

  state_t            state, state_n;
  alpha_t            cur, nxt;
  logic [ITER_W-1:0] max_iter_r;
  logic [W-1:0]      eps_r;
  logic [P_W-1:0]    idx;
  logic [W:0]        run_max, pt_delta, max_upd;
  logic              last_pt, conv_hit, limit_hit, take_abort;

  // Single delta unit, time-shared across points by the CMP index.
  pbvi_point_delta #(
    .N_ST (N_ST),
    .W    (W)
  ) u_point_delta (
    .cur_pt (cur[idx]),
    .nxt_pt (nxt[idx]),
    .delta  (pt_delta)
  );

  assign eng.step_alpha = cur;
  assign alpha_out      = cur;

  always_comb begin
    max_upd    = (pt_delta > run_max) ? pt_delta : run_max;
    last_pt    = (idx == P_W'(N_PTS - 1));
    conv_hit   = (max_upd <= {1'b0, eps_r});
    limit_hit  = (iter_count == max_iter_r);
    take_abort = abort && (state != S_IDLE);
    state_n    = state;
    unique case (state)
      S_IDLE:      if (start) state_n = S_LOAD;
      S_LOAD:      state_n = (max_iter_r == '0) ? S_DONE : S_STEP_REQ;
      S_STEP_REQ:  state_n = S_STEP_WAIT;
      S_STEP_WAIT: if (eng.step_done) state_n = S_CMP;
      // Convergence and the limit both end the solve; which flag is set is
      // decided in the register block.
      S_CMP:       if (last_pt) state_n = (conv_hit || limit_hit) ? S_DONE : S_STEP_REQ;
      S_DONE:      state_n = S_IDLE;
      default:     state_n = S_IDLE;
    endcase
    if (take_abort) state_n = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  // Status outputs are decoded from the next state so they are registered
  // yet line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eng.step_start <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      aborted        <= 1'b0;
      converged      <= 1'b0;
      iter_count     <= '0;
      last_delta     <= '0;
      point_action   <= '0;
      cur            <= '0;
      nxt            <= '0;
      max_iter_r     <= '0;
      eps_r          <= '0;
      idx            <= '0;
      run_max        <= '0;
    end else begin
      eng.step_start <= (state_n == S_STEP_REQ);
      busy           <= (state_n != S_IDLE);
      done           <= (state_n == S_DONE);
      aborted        <= take_abort;
      if (!take_abort) begin
        unique case (state)
          S_IDLE: begin
            if (start) begin
              max_iter_r <= max_iter;
              eps_r      <= epsilon;
              cur        <= alpha_in;
              converged  <= 1'b0;
            end
          end
          S_LOAD: begin
            iter_count <= '0;
            last_delta <= '0;
          end
          S_STEP_WAIT: begin
            if (eng.step_done) begin
              nxt          <= eng.step_alpha_res;
              point_action <= eng.step_action;
              iter_count   <= iter_count + ITER_W'(1);
              idx          <= '0;
              run_max      <= '0;
            end
          end
          S_CMP: begin
            run_max <= max_upd;
            idx     <= idx + P_W'(1);
            if (last_pt) begin
              cur        <= nxt;
              last_delta <= max_upd;
              if (conv_hit) converged <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pbvi_iter_ctrl.sv
// Bench for pbvi_iter_ctrl with a behavioural backup engine (3-cycle latency)
// whose transfer function is selected per solve.
module tb_pbvi_iter_ctrl;
  localparam int N_PTS = 16, N_ST = 2, N_ACT = 3, W = 16, ITER_W = 16, A_W = 2;
  localparam int LAT = 3;

  typedef logic [N_PTS-1:0][N_ST-1:0][W-1:0] alpha_t;
  typedef struct {
    logic              conv;
    logic [ITER_W-1:0] iters;
    logic [W:0]        delta;
    alpha_t            alpha;
    logic [N_PTS*A_W-1:0] act;
    bit                chk_act;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, abort = 1'b0;
  logic [ITER_W-1:0] max_iter = '0;
  logic [W-1:0] epsilon = '0;
  alpha_t alpha_in = '0;
  logic busy, done, converged, aborted;
  logic [ITER_W-1:0] iter_count;
  logic [W:0] last_delta;
  logic [N_PTS*N_ST*W-1:0] alpha_out;
  logic [N_PTS*A_W-1:0] point_action;

  pbvi_iter_ctrl_if #(.N_PTS(N_PTS), .N_ST(N_ST), .N_ACT(N_ACT), .W(W), .A_W(A_W)) eng ();

  pbvi_iter_ctrl #(.N_PTS(N_PTS), .N_ST(N_ST), .N_ACT(N_ACT), .W(W), .ITER_W(ITER_W), .A_W(A_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .max_iter(max_iter),
    .epsilon(epsilon), .alpha_in(alpha_in), .eng(eng), .busy(busy), .done(done),
    .converged(converged), .aborted(aborted), .iter_count(iter_count),
    .last_delta(last_delta), .alpha_out(alpha_out), .point_action(point_action)
  );

  always #5 clk = ~clk;

  int n_pass = 0, n_fail = 0, n_total = 0;
  int eng_mode = 0, eng_cnt = 0, n_steps = 0, n_resp = 0, n_dut_done = 0;
  bit late_req = 1'b0;
  alpha_t held;
  exp_t sb_q[$];

  function automatic alpha_t eng_f(input int mode, input alpha_t a);
    alpha_t r = a;
    for (int p = 0; p < N_PTS; p++)
      for (int s = 0; s < N_ST; s++)
        case (mode)
          1: r[p][s] = a[p][s] + 16'd4;
          2: if (p == 0 && s == 0) r[p][s] = 16'h7FFF;
          default: ;
        endcase
    return r;
  endfunction

  function automatic logic [N_PTS*A_W-1:0] act_f(input int mode);
    logic [N_PTS*A_W-1:0] r = '0;
    for (int p = 0; p < N_PTS; p++) r[p*A_W +: A_W] = A_W'((p + mode) % N_ACT);
    return r;
  endfunction

  function automatic exp_t model(input int mode, input alpha_t a0,
                                 input logic [W-1:0] eps, input logic [ITER_W-1:0] mi);
    exp_t e;
    alpha_t c = a0, n;
    int d, df;
    e.conv = 1'b0; e.iters = '0; e.delta = '0; e.act = act_f(mode); e.chk_act = (mi != 0);
    if (mi != 0)
      for (int k = 0; k < 1000; k++) begin
        n = eng_f(mode, c);
        d = 0;
        for (int p = 0; p < N_PTS; p++)
          for (int s = 0; s < N_ST; s++) begin
            df = int'($signed(n[p][s])) - int'($signed(c[p][s]));
            if (df < 0) df = -df;
            if (df > d) d = df;
          end
        c = n;
        e.iters = e.iters + 1'b1;
        e.delta = (W+1)'(d);
        if (d <= int'(eps)) begin e.conv = 1'b1; break; end
        if (e.iters == mi) break;
      end
    e.alpha = c;
    return e;
  endfunction

  // Behavioural backup engine plus pulse counters.
  initial begin
    eng.step_done = 1'b0; eng.step_alpha_res = '0; eng.step_action = '0;
    forever begin
      @(posedge clk); #1;
      eng.step_done = 1'b0;
      if (!rst_n) begin
        eng_cnt = 0;
      end else begin
        if (done) n_dut_done++;
        if (eng_cnt > 0) begin
          eng_cnt--;
          if (eng_cnt == 0) begin
            eng.step_done = 1'b1;
            eng.step_alpha_res = eng_f(eng_mode, held);
            eng.step_action = act_f(eng_mode);
            n_resp++;
          end
        end else if (late_req) begin
          late_req = 1'b0;
          eng.step_done = 1'b1;
          eng.step_alpha_res = '1;
          eng.step_action = '1;
        end
        if (eng.step_start) begin
          n_steps++;
          held = eng.step_alpha;
          eng_cnt = LAT;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic start_solve(input int mode, input alpha_t a, input logic [W-1:0] eps,
                             input logic [ITER_W-1:0] mi, input bit push, input bit hold);
    if (push) sb_q.push_back(model(mode, a, eps, mi));
    eng_mode = mode; alpha_in = a; epsilon = eps; max_iter = mi;
    start = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
  endtask

  task automatic finish_solve(input string tag, output int cyc);
    exp_t e;
    cyc = 1;
    while (!done && cyc < 3000) begin @(negedge clk); cyc++; end
    start = 1'b0;
    check({tag, "_done_seen"}, 512'(done), 512'(1));
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 512'(0), 512'(1));
    end else begin
      e = sb_q.pop_front();
      check({tag, "_converged"}, 512'(converged), 512'(e.conv));
      check({tag, "_iter_count"}, 512'(iter_count), 512'(e.iters));
      check({tag, "_last_delta"}, 512'(last_delta), 512'(e.delta));
      check({tag, "_alpha_out"}, 512'(alpha_out), 512'(e.alpha));
      if (e.chk_act) check({tag, "_point_action"}, 512'(point_action), 512'(e.act));
    end
    @(negedge clk);
    check({tag, "_idle_after"}, 512'({busy, done}), 512'(0));
  endtask

  alpha_t a0, a1;
  int cyc, s0, d0, r0, wait_n;
  logic [ITER_W-1:0] ic0;

  initial begin
    for (int p = 0; p < N_PTS; p++)
      for (int s = 0; s < N_ST; s++) begin
        a0[p][s] = W'($urandom_range(0, 16383));
        a1[p][s] = W'($urandom_range(0, 16383));
      end

    // Reset state
    tick(3);
    check("rst_status", 512'({busy, done, converged, aborted, eng.step_start}), 512'(0));
    check("rst_counts", 512'({iter_count, last_delta, point_action}), 512'(0));
    check("rst_alpha", 512'(alpha_out), 512'(0));
    check("rst_step_alpha", 512'(eng.step_alpha), 512'(0));
    rst_n = 1'b1;
    tick(2);

    // Identity engine converges after one backup; 22-cycle solve
    start_solve(0, a0, 16'd0, 16'd10, 1'b1, 1'b0);
    check("t1_busy", 512'(busy), 512'(1));
    finish_solve("t1", cyc);
    check("t1_cycles", 512'(cyc), 512'(22));

    // +4 per backup never reaches epsilon = 3; stops on limit 5
    start_solve(1, a0, 16'd3, 16'd5, 1'b1, 1'b0);
    finish_solve("t2", cyc);
    check("t2_delta_const", 512'(last_delta), 512'(17'd4));
    check("t2_elem0", 512'(alpha_out[15:0]), 512'(a0[0][0] + 16'd20));

    // Full-span change 0x8000 -> 0x7FFF must not wrap
    a1[0][0] = 16'h8000;
    start_solve(2, a1, 16'hFFFE, 16'd1, 1'b1, 1'b0);
    finish_solve("t3", cyc);
    check("t3_span", 512'(last_delta), 512'(17'h0FFFF));

    // max_iter = 0: done in cycle 2, engine never launched
    s0 = n_steps;
    start_solve(0, a0, 16'd0, 16'd0, 1'b1, 1'b0);
    finish_solve("t4", cyc);
    check("t4_cycles", 512'(cyc), 512'(2));
    check("t4_no_step", 512'(n_steps - s0), 512'(0));

    // Abort during the second CMP pass, then a late step_done
    r0 = n_resp;
    d0 = n_dut_done;
    start_solve(1, a0, 16'd0, 16'd5, 1'b0, 1'b0);
    wait_n = 0;
    while (n_resp < r0 + 2 && wait_n < 500) begin @(negedge clk); wait_n++; end
    check("t5_second_resp", 512'(n_resp - r0), 512'(2));
    tick(4);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("t5_aborted", 512'({aborted, busy, done}), 512'(3'b100));
    late_req = 1'b1;
    tick(4);
    check("t5_alpha_kept", 512'(alpha_out), 512'(eng_f(1, a0)));
    check("t5_iter_count", 512'(iter_count), 512'(2));
    check("t5_no_done", 512'(n_dut_done - d0), 512'(0));
    check("t5_quiet", 512'({busy, aborted}), 512'(0));
    start_solve(0, a1, 16'd0, 16'd10, 1'b1, 1'b0);
    finish_solve("t5_restart", cyc);

    // Stray step_done in IDLE, then start held through a whole solve
    ic0 = iter_count;
    late_req = 1'b1;
    tick(4);
    check("t6_idle_stray", 512'({busy, iter_count}), 512'({1'b0, ic0}));
    s0 = n_steps;
    d0 = n_dut_done;
    start_solve(1, a0, 16'd3, 16'd2, 1'b1, 1'b1);
    finish_solve("t6", cyc);
    tick(3);
    check("t6_one_solve", 512'({n_steps - s0, n_dut_done - d0}), 512'({32'd2, 32'd1}));

    // Asynchronous reset while waiting on the engine
    s0 = n_steps;
    start_solve(0, a0, 16'd0, 16'd10, 1'b0, 1'b0);
    wait_n = 0;
    while (n_steps == s0 && wait_n < 50) begin @(negedge clk); wait_n++; end
    @(negedge clk);
    check("t7_pre_busy", 512'(busy), 512'(1));
    #2 rst_n = 1'b0;
    #1;
    check("t7_rst_status", 512'({busy, done, converged, aborted, eng.step_start}), 512'(0));
    check("t7_rst_data", 512'({iter_count, last_delta, point_action}), 512'(0));
    check("t7_rst_alpha", 512'(alpha_out), 512'(0));
    @(negedge clk);
    rst_n = 1'b1;
    tick(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end
endmodule
